reg_write_arbiter: RTL

//  Round-robin arbiter that shares one WIDTH-bit register (SB_DFF-per-bit bank) among N requesters.

---
 rtl/reg_write_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter sharing one WIDTH-bit register among N requesters.
// Each grant loads the winner's payload into O with a one-cycle GNT/VALID pulse,
// followed by a mandatory ACK cycle so a granted requester is never re-granted
// on a stale REQ.
// Optional feature macro: REGARB_LOCK_EN -- a winner holding LOCK keeps ownership
// of the register across consecutive writes. Undefined: LOCK is ignored.
module reg_write_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 7,
  parameter int unsigned SW    = 2
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic [N-1:0]         REQ,
  input  logic [N*WIDTH-1:0]   DATA,
  input  logic [N-1:0]         LOCK,
  output logic [N-1:0]         GNT,
  output logic [WIDTH-1:0]     O,
  output logic                 VALID,
  output logic [SW-1:0]        SRC,
  output logic                 BUSY
);

  localparam int unsigned SUMW = SW + 1;

  typedef enum logic [0:0] {
    ST_ARB = 1'b0,
    ST_ACK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             valid_q, valid_d;
  logic [SW-1:0]    src_q, src_d;
  logic             busy_q, busy_d;
  logic [SW-1:0]    ptr_q, ptr_d;

  logic [SW-1:0]    ptr_base;
  logic [SW-1:0]    win;
  logic             win_vld;

`ifdef REGARB_LOCK_EN
  logic             own_vld_q, own_vld_d;
  logic [SW-1:0]    own_q, own_d;
  logic             owner_hold;
`else
  logic             unused_lock;
  assign unused_lock = ^LOCK;
`endif

  // (x + 1) mod N
  function automatic logic [SW-1:0] inc_mod(input logic [SW-1:0] x);
    if (32'(x) == N - 1) return '0;
    return x + SW'(1);
  endfunction

  // (b + k) mod N for k < N
  function automatic logic [SW-1:0] add_mod(input logic [SW-1:0] b, input int unsigned k);
    logic [SUMW-1:0] sum;
    sum = {1'b0, b} + SUMW'(k);
    if (sum >= SUMW'(N)) sum = sum - SUMW'(N);
    return sum[SW-1:0];
  endfunction

  // Winner search: lock owner first (if enabled), else first requester from the pointer
  always_comb begin
    ptr_base = ptr_q;
`ifdef REGARB_LOCK_EN
    owner_hold = 1'b0;
    if (own_vld_q) begin
      if (REQ[own_q] && LOCK[own_q]) owner_hold = 1'b1;
      else                           ptr_base   = inc_mod(own_q);
    end
`endif
    win     = ptr_base;
    win_vld = 1'b0;
    // Descending scan so the lowest offset from ptr_base wins
    for (int k = N - 1; k >= 0; k--) begin
      if (REQ[add_mod(ptr_base, 32'(k))]) begin
        win     = add_mod(ptr_base, 32'(k));
        win_vld = 1'b1;
      end
    end
`ifdef REGARB_LOCK_EN
    if (owner_hold) begin
      win     = own_q;
      win_vld = 1'b1;
    end
`endif
  end

  // State register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= ST_ARB;
    else         state_q <= state_d;
  end

  // Next-state logic: every write is followed by one ACK cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:  if (win_vld) state_d = ST_ACK;
      ST_ACK:  state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    gnt_d   = '0;
    valid_d = 1'b0;
    o_d     = o_q;
    src_d   = src_q;
    busy_d  = (state_q == ST_ACK);
    ptr_d   = ptr_q;
`ifdef REGARB_LOCK_EN
    own_vld_d = own_vld_q;
    own_d     = own_q;
`endif
    if (state_q == ST_ARB) begin
`ifdef REGARB_LOCK_EN
      // Ownership ends: resume round-robin just past the old owner
      if (own_vld_q && !owner_hold) begin
        own_vld_d = 1'b0;
        ptr_d     = ptr_base;
      end
`endif
      if (win_vld) begin
        o_d        = DATA[32'(win)*WIDTH +: WIDTH];
        gnt_d[win] = 1'b1;
        valid_d    = 1'b1;
        src_d      = win;
`ifdef REGARB_LOCK_EN
        if (LOCK[win]) begin
          own_vld_d = 1'b1;
          own_d     = win;
          ptr_d     = ptr_base;
        end else begin
          ptr_d     = inc_mod(win);
        end
`else
        ptr_d = inc_mod(win);
`endif
      end
    end
  end

  // Registered outputs and arbitration state
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      gnt_q   <= '0;
      o_q     <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
`ifdef REGARB_LOCK_EN
      own_vld_q <= 1'b0;
      own_q     <= '0;
`endif
    end else begin
      gnt_q   <= gnt_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
`ifdef REGARB_LOCK_EN
      own_vld_q <= own_vld_d;
      own_q     <= own_d;
`endif
    end
  end

  assign GNT   = gnt_q;
  assign O     = o_q;
  assign VALID = valid_q;
  assign SRC   = src_q;
  assign BUSY  = busy_q;

endmodule
